// File: rtl/acc_icb_pkg.sv
// acc_icb_pkg
//   Shared definitions for the accelerator ICB register slave: register
//   offsets inside the 4 KB window, CTRL/STATUS bit positions, the register
//   selector enum, the response-queue entry type and the offset decoder.
package acc_icb_pkg;

  // Offset bits inside the register window; the upper 32-WIN_OFF_W address
  // bits must match the base address.
  localparam int WIN_OFF_W = 12;

  localparam logic [WIN_OFF_W-1:0] OFF_CTRL   = 12'h000;
  localparam logic [WIN_OFF_W-1:0] OFF_STATUS = 12'h004;
  localparam logic [WIN_OFF_W-1:0] OFF_IFM    = 12'h008;
  localparam logic [WIN_OFF_W-1:0] OFF_WGT    = 12'h00C;
  localparam logic [WIN_OFF_W-1:0] OFF_OFM    = 12'h010;
  localparam logic [WIN_OFF_W-1:0] OFF_LAYER  = 12'h014;
  localparam logic [WIN_OFF_W-1:0] OFF_CYCLE  = 12'h018;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STATUS,
    REG_IFM,
    REG_WGT,
    REG_OFM,
    REG_LAYER,
    REG_CYCLE,
    REG_NONE
  } reg_sel_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_entry_t;

  // Only exact word offsets are mapped; anything else (including misaligned
  // byte addresses of a mapped word) is a decode error.
  function automatic reg_sel_e decode_offset(input logic [WIN_OFF_W-1:0] off);
    case (off)
      OFF_CTRL:   return REG_CTRL;
      OFF_STATUS: return REG_STATUS;
      OFF_IFM:    return REG_IFM;
      OFF_WGT:    return REG_WGT;
      OFF_OFM:    return REG_OFM;
      OFF_LAYER:  return REG_LAYER;
      OFF_CYCLE:  return REG_CYCLE;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/acc_icb_if.sv
// acc_icb_if
//   ICB command/response channel between the core (master) and the
//   accelerator register slave.
//   Command : icb_cmd_valid/ready, icb_cmd_read, icb_cmd_addr[31:0],
//             icb_cmd_wdata[31:0], icb_cmd_wmask[3:0]
//   Response: icb_rsp_valid/ready, icb_rsp_rdata[31:0], icb_rsp_err
interface acc_icb_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata,
           icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata,
           icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );
endinterface

// File: rtl/icb_rsp_fifo.sv
// icb_rsp_fifo
//   Two-entry in-order response queue.
//   clk, rst        : clock, synchronous active-high reset (flushes queue)
//   push, push_data : enqueue one rsp_entry_t (ignored when full)
//   pop             : dequeue the head entry (ignored when empty)
//   head            : current head entry, all-zero while empty
//   count/full/empty: registered occupancy
module icb_rsp_fifo
  import acc_icb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rsp_entry_t push_data,
  input  logic       pop,
  output rsp_entry_t head,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  rsp_entry_t mem_reg [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (count_reg == 2'd2);
  assign empty   = (count_reg == 2'd0);
  assign count   = count_reg;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Zero the visible head while empty so rdata/err read 0 when idle.
  assign head = empty ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop_ok) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/acc_icb_slave.sv
// acc_icb_slave
//   ICB register slave in front of the RepVGG accelerator. Decodes each
//   command against a small CSR file and queues one response per command.
//   Parameters: BASE_ADDR (4 KB window base), CNT_W (busy-cycle counter width)
//   clk, rst     : clock, synchronous active-high reset
//   bus          : ICB slave modport (command in, response out)
//   acc_start    : one-cycle start pulse to the accelerator
//   acc_done     : one-cycle completion pulse from the accelerator
//   cfg_*_addr   : buffer base addresses; cfg_layer: layer config word
//   irq          : level interrupt, DONE & IRQ_EN registered
module acc_icb_slave
  import acc_icb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  acc_icb_if.slave    bus,
  output logic        acc_start,
  input  logic        acc_done,
  output logic [31:0] cfg_ifm_addr,
  output logic [31:0] cfg_wgt_addr,
  output logic [31:0] cfg_ofm_addr,
  output logic [15:0] cfg_layer,
  output logic        irq
);

  logic             cmd_ready_reg;
  logic             irq_en_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [31:0]      ifm_reg;
  logic [31:0]      wgt_reg;
  logic [31:0]      ofm_reg;
  logic [15:0]      layer_reg;
  logic [CNT_W-1:0] cycle_cnt_reg;
  logic             acc_start_reg;
  logic             irq_reg;

  logic             cmd_fire;
  logic             rsp_fire;
  logic             in_window;
  reg_sel_e         sel;
  logic             hit;
  logic             wr_fire;
  logic             start_go;
  logic             done_clr;
  logic             done_set;
  logic [31:0]      rd_data;
  logic [31:0]      byte_en;
  rsp_entry_t       rsp_in;
  rsp_entry_t       rsp_head;
  logic [1:0]       fifo_count;
  logic [1:0]       count_next;
  logic             fifo_full;
  logic             fifo_empty;

  genvar gi;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  assign cmd_fire  = bus.icb_cmd_valid & cmd_ready_reg;
  assign rsp_fire  = ~fifo_empty & bus.icb_rsp_ready;
  assign in_window = (bus.icb_cmd_addr[31:WIN_OFF_W] == BASE_ADDR[31:WIN_OFF_W]);
  assign sel       = in_window ? decode_offset(bus.icb_cmd_addr[WIN_OFF_W-1:0]) : REG_NONE;
  assign hit       = (sel != REG_NONE);
  assign wr_fire   = cmd_fire & ~bus.icb_cmd_read & hit;

  // Expand the byte mask to a bit mask for read-modify-write merges.
  for (gi = 0; gi < 4; gi++) begin : g_byte_en
    assign byte_en[8*gi +: 8] = {8{bus.icb_cmd_wmask[gi]}};
  end

  // START/DONE bits live in byte 0, so they only act when wmask[0] is set.
  assign start_go = wr_fire & (sel == REG_CTRL) & bus.icb_cmd_wmask[0]
                  & bus.icb_cmd_wdata[CTRL_START_BIT] & ~busy_reg;
  assign done_clr = wr_fire & (sel == REG_STATUS) & bus.icb_cmd_wmask[0]
                  & bus.icb_cmd_wdata[STATUS_DONE_BIT];
  assign done_set = acc_done & busy_reg;

  // Read mux reflects register state before this edge's writes.
  always_comb begin
    rd_data = '0;
    case (sel)
      REG_CTRL:   rd_data[CTRL_IRQ_EN_BIT] = irq_en_reg;
      REG_STATUS: begin
        rd_data[STATUS_BUSY_BIT] = busy_reg;
        rd_data[STATUS_DONE_BIT] = done_reg;
      end
      REG_IFM:    rd_data = ifm_reg;
      REG_WGT:    rd_data = wgt_reg;
      REG_OFM:    rd_data = ofm_reg;
      REG_LAYER:  rd_data[15:0] = layer_reg;
      REG_CYCLE:  rd_data = 32'(cycle_cnt_reg);
      default:    rd_data = '0;
    endcase
  end

  always_comb begin
    rsp_in       = '0;
    rsp_in.err   = ~hit;
    rsp_in.rdata = (bus.icb_cmd_read & hit) ? rd_data : 32'd0;
  end

  // Next occupancy, used to register cmd_ready so it never depends
  // combinationally on icb_rsp_ready.
  always_comb begin
    count_next = fifo_count;
    if (cmd_fire && !rsp_fire) begin
      count_next = fifo_count + 2'd1;
    end else if (!cmd_fire && rsp_fire) begin
      count_next = fifo_count - 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_reg <= 1'b0;
      irq_en_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      ifm_reg       <= '0;
      wgt_reg       <= '0;
      ofm_reg       <= '0;
      layer_reg     <= '0;
      cycle_cnt_reg <= '0;
      acc_start_reg <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      cmd_ready_reg <= (count_next != 2'd2);
      acc_start_reg <= start_go;

      if (wr_fire && (sel == REG_CTRL) && bus.icb_cmd_wmask[0]) begin
        irq_en_reg <= bus.icb_cmd_wdata[CTRL_IRQ_EN_BIT];
      end
      if (wr_fire && (sel == REG_IFM)) begin
        ifm_reg <= (ifm_reg & ~byte_en) | (bus.icb_cmd_wdata & byte_en);
      end
      if (wr_fire && (sel == REG_WGT)) begin
        wgt_reg <= (wgt_reg & ~byte_en) | (bus.icb_cmd_wdata & byte_en);
      end
      if (wr_fire && (sel == REG_OFM)) begin
        ofm_reg <= (ofm_reg & ~byte_en) | (bus.icb_cmd_wdata & byte_en);
      end
      if (wr_fire && (sel == REG_LAYER)) begin
        layer_reg <= (layer_reg & ~byte_en[15:0]) | (bus.icb_cmd_wdata[15:0] & byte_en[15:0]);
      end

      // done_set needs busy=1 and start_go needs busy=0, so they never collide.
      if (done_set) begin
        busy_reg <= 1'b0;
      end else if (start_go) begin
        busy_reg <= 1'b1;
      end

      // A completion arriving with a W1C clear keeps DONE set.
      if (done_set) begin
        done_reg <= 1'b1;
      end else if (done_clr) begin
        done_reg <= 1'b0;
      end

      if (start_go) begin
        cycle_cnt_reg <= '0;
      end else if (busy_reg) begin
        cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
      end

      irq_reg <= done_reg & irq_en_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Response queue
  // ---------------------------------------------------------------------------
  icb_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_fire),
    .push_data (rsp_in),
    .pop       (rsp_fire),
    .head      (rsp_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.icb_cmd_ready = cmd_ready_reg;
  assign bus.icb_rsp_valid = ~fifo_empty;
  assign bus.icb_rsp_rdata = rsp_head.rdata;
  assign bus.icb_rsp_err   = rsp_head.err;

  assign acc_start    = acc_start_reg;
  assign irq          = irq_reg;
  assign cfg_ifm_addr = ifm_reg;
  assign cfg_wgt_addr = wgt_reg;
  assign cfg_ofm_addr = ofm_reg;
  assign cfg_layer    = layer_reg;

  // fifo_full is implied by the registered ready; kept for visibility only.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_acc_icb_slave.sv
// tb_acc_icb_slave
//   Directed bench for acc_icb_slave: a vector table of single ICB
//   transactions followed by hand-written sequences for start/done timing,
//   response backpressure and reset during a pending response.
module tb_acc_icb_slave;

  localparam logic [31:0] A = 32'h1004_2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acc_start;
  logic        acc_done = 1'b0;
  logic [31:0] cfg_ifm_addr;
  logic [31:0] cfg_wgt_addr;
  logic [31:0] cfg_ofm_addr;
  logic [15:0] cfg_layer;
  logic        irq;

  int checks = 0;
  int failures = 0;
  int start_pulses = 0;
  int cyc = 0;

  acc_icb_if bus();

  acc_icb_slave #(.BASE_ADDR(32'h1004_2000), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .acc_start    (acc_start),
    .acc_done     (acc_done),
    .cfg_ifm_addr (cfg_ifm_addr),
    .cfg_wgt_addr (cfg_wgt_addr),
    .cfg_ofm_addr (cfg_ofm_addr),
    .cfg_layer    (cfg_layer),
    .irq          (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && acc_start === 1'b1) start_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.rd = rd; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One ICB transaction with icb_rsp_ready held high. Returns at the negedge
  // one cycle after acceptance, where the response must already be valid.
  task automatic icb_xfer(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic pulse_done,
                          output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_read  = rd;
    bus.icb_cmd_addr  = addr;
    bus.icb_cmd_wdata = wdata;
    bus.icb_cmd_wmask = wmask;
    acc_done          = pulse_done;
    n = 0;
    while (bus.icb_cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout: got ready=%b required 1 within 50 cycles", bus.icb_cmd_ready);
    end
    @(posedge clk);
    #1;
    bus.icb_cmd_valid = 1'b0;
    acc_done          = 1'b0;
    @(negedge clk);
    chk("rsp_valid_latency", 32'(bus.icb_rsp_valid), 32'd1);
    rdata = bus.icb_rsp_rdata;
    err   = bus.icb_rsp_err;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    icb_xfer(1'b1, addr, 32'd0, 4'd0, 1'b0, d, e);
    $display("read  %s addr=%08h -> rdata=%08h err=%b", name, addr, d, e);
    chk(name, d, exp);
    chk({name, "_err"}, 32'(e), 32'd0);
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [3:0] wmask, input logic pulse_done);
    logic [31:0] d;
    logic        e;
    icb_xfer(1'b0, addr, wdata, wmask, pulse_done, d, e);
    $display("write %s addr=%08h wdata=%08h mask=%b -> rdata=%08h err=%b", name, addr, wdata, wmask, d, e);
    chk({name, "_err"}, 32'(e), 32'd0);
  endtask

  logic [32:0] got[$];
  logic [31:0] d;
  logic        e;
  int          c0;
  logic        acc_c;

  initial begin
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_addr  = '0;
    bus.icb_cmd_wdata = '0;
    bus.icb_cmd_wmask = '0;
    bus.icb_rsp_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.icb_cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.icb_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.icb_rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.icb_rsp_err), 32'd0);
    chk("rst_acc_start", 32'(acc_start), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_cfg_ifm", cfg_ifm_addr, 32'd0);
    chk("rst_cfg_layer", 32'(cfg_layer), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(bus.icb_cmd_ready), 32'd1);

    // ---------------- table-driven single transactions ----------------
    add_vec(1, A + 32'h04, 32'h0, 4'h0, 32'h0000_0000, 0);
    add_vec(1, A + 32'h08, 32'h0, 4'h0, 32'h0000_0000, 0);
    add_vec(0, A + 32'h08, 32'hDEAD_BEEF, 4'b0101, 32'h0, 0);
    add_vec(1, A + 32'h08, 32'h0, 4'h0, 32'h00AD_00EF, 0);
    add_vec(1, 32'h1004_2040, 32'h0, 4'h0, 32'h0, 1);
    add_vec(1, 32'h1004_3000, 32'h0, 4'h0, 32'h0, 1);
    add_vec(0, 32'h1004_3008, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
    add_vec(0, 32'h1004_2009, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
    add_vec(1, A + 32'h08, 32'h0, 4'h0, 32'h00AD_00EF, 0);
    add_vec(0, A + 32'h0C, 32'h1234_5678, 4'hF, 32'h0, 0);
    add_vec(1, A + 32'h0C, 32'h0, 4'h0, 32'h1234_5678, 0);
    add_vec(0, A + 32'h10, 32'hA5A5_A5A5, 4'b1000, 32'h0, 0);
    add_vec(1, A + 32'h10, 32'h0, 4'h0, 32'hA500_0000, 0);
    add_vec(0, A + 32'h14, 32'hCAFE_BABE, 4'hF, 32'h0, 0);
    add_vec(1, A + 32'h14, 32'h0, 4'h0, 32'h0000_BABE, 0);
    add_vec(0, A + 32'h18, 32'hFFFF_FFFF, 4'hF, 32'h0, 0);
    add_vec(1, A + 32'h18, 32'h0, 4'h0, 32'h0000_0000, 0);
    add_vec(0, A + 32'h00, 32'h0000_0003, 4'b1110, 32'h0, 0);
    add_vec(1, A + 32'h00, 32'h0, 4'h0, 32'h0000_0000, 0);
    add_vec(0, A + 32'h00, 32'h0000_0002, 4'b0001, 32'h0, 0);
    add_vec(1, A + 32'h00, 32'h0, 4'h0, 32'h0000_0002, 0);
    add_vec(0, A + 32'h04, 32'h0000_0003, 4'hF, 32'h0, 0);
    add_vec(1, A + 32'h04, 32'h0, 4'h0, 32'h0000_0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      icb_xfer(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, 1'b0, d, e);
      $display("vec %0d rd=%b addr=%08h wdata=%08h mask=%b -> rdata=%08h err=%b", i,
               vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, d, e);
      chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
    end
    chk("cfg_ifm", cfg_ifm_addr, 32'h00AD_00EF);
    chk("cfg_wgt", cfg_wgt_addr, 32'h1234_5678);
    chk("cfg_ofm", cfg_ofm_addr, 32'hA500_0000);
    chk("cfg_layer", 32'(cfg_layer), 32'h0000_BABE);
    chk("no_start_yet", 32'(start_pulses), 32'd0);
    chk("irq_idle", 32'(irq), 32'd0);

    // ---------------- start / done / cycle count / irq ----------------
    wr("start1", A + 32'h00, 32'h3, 4'b0001, 1'b0);
    c0 = cyc;
    chk("start_pulse_hi", 32'(acc_start), 32'd1);
    @(negedge clk);
    chk("start_pulse_lo", 32'(acc_start), 32'd0);
    rd_chk("status_busy", A + 32'h04, 32'h1);
    while (cyc < c0 + 9) @(negedge clk);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    chk("irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'd1);
    rd_chk("status_done", A + 32'h04, 32'h2);
    rd_chk("cycle_cnt", A + 32'h18, 32'd10);
    wr("done_w1c", A + 32'h04, 32'h2, 4'b0001, 1'b0);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'd0);
    rd_chk("status_clear", A + 32'h04, 32'h0);
    chk("one_pulse", 32'(start_pulses), 32'd1);

    // ---------------- start while busy, done with W1C ----------------
    wr("start2", A + 32'h00, 32'h3, 4'b0001, 1'b0);
    wr("start_busy", A + 32'h00, 32'h3, 4'b0001, 1'b0);
    repeat (2) @(negedge clk);
    chk("no_second_pulse", 32'(start_pulses), 32'd2);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    rd_chk("status_done2", A + 32'h04, 32'h2);
    wr("start3", A + 32'h00, 32'h3, 4'b0001, 1'b0);
    rd_chk("status_busy_done", A + 32'h04, 32'h3);
    wr("w1c_with_done", A + 32'h04, 32'h2, 4'b0001, 1'b1);
    rd_chk("set_wins", A + 32'h04, 32'h2);
    wr("w1c_alone", A + 32'h04, 32'h2, 4'b0001, 1'b0);
    @(negedge clk);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    rd_chk("done_idle_ignored", A + 32'h04, 32'h0);
    chk("three_pulses", 32'(start_pulses), 32'd3);

    // ---------------- response backpressure ----------------
    @(negedge clk);
    bus.icb_rsp_ready = 1'b0;
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_read  = 1'b1;
    bus.icb_cmd_addr  = A + 32'h08;
    @(posedge clk);
    #1 bus.icb_cmd_addr = A + 32'h0C;
    @(posedge clk);
    #1 bus.icb_cmd_addr = A + 32'h14;
    @(negedge clk);
    chk("bp_cmd_ready_low", 32'(bus.icb_cmd_ready), 32'd0);
    chk("bp_rsp_valid", 32'(bus.icb_rsp_valid), 32'd1);
    repeat (3) @(negedge clk);
    chk("bp_cmd_ready_held", 32'(bus.icb_cmd_ready), 32'd0);
    chk("bp_rdata_stable", bus.icb_rsp_rdata, 32'h00AD_00EF);
    bus.icb_rsp_ready = 1'b1;
    for (int k = 0; k < 20 && got.size() < 3; k++) begin
      if (bus.icb_rsp_valid === 1'b1) got.push_back({bus.icb_rsp_err, bus.icb_rsp_rdata});
      acc_c = bus.icb_cmd_valid & bus.icb_cmd_ready;
      @(posedge clk);
      #1;
      if (acc_c) bus.icb_cmd_valid = 1'b0;
      @(negedge clk);
    end
    bus.icb_cmd_valid = 1'b0;
    chk("bp_rsp_count", 32'(got.size()), 32'd3);
    while (got.size() < 3) got.push_back(33'h1_FFFF_FFFF);
    $display("bp responses: %09h %09h %09h", got[0], got[1], got[2]);
    chk("bp_rsp0", got[0][31:0], 32'h00AD_00EF);
    chk("bp_rsp1", got[1][31:0], 32'h1234_5678);
    chk("bp_rsp2", got[2][31:0], 32'h0000_BABE);
    chk("bp_errs", 32'({got[0][32], got[1][32], got[2][32]}), 32'd0);

    // ---------------- reset with a pending response ----------------
    wr("start4", A + 32'h00, 32'h1, 4'b0001, 1'b0);
    @(negedge clk);
    bus.icb_rsp_ready = 1'b0;
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_read  = 1'b1;
    bus.icb_cmd_addr  = A + 32'h04;
    @(posedge clk);
    #1 bus.icb_cmd_valid = 1'b0;
    @(negedge clk);
    chk("pending_rsp", 32'(bus.icb_rsp_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("flush_rsp_valid", 32'(bus.icb_rsp_valid), 32'd0);
    chk("flush_cmd_ready", 32'(bus.icb_cmd_ready), 32'd0);
    rst = 1'b0;
    bus.icb_rsp_ready = 1'b1;
    @(negedge clk);
    rd_chk("rst_busy_cleared", A + 32'h04, 32'h0);
    rd_chk("rst_ifm_cleared", A + 32'h08, 32'h0);
    chk("rst_cfg_ifm2", cfg_ifm_addr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_icb_slave.md
# acc_icb_slave

ICB slave that terminates the core-side ICB command channel in front of the RepVGG accelerator. Decodes each command into a small control/status register file (start, done, buffer base addresses, layer config, cycle counter) and returns one response per command through a 2-entry response queue. Drives the accelerator's start/config inputs and an interrupt. It is the design-side consumer of the ICB bus that the testbench interface drives.

## Interface
- BASE_ADDR, 32'h1004_2000, base of the 4 KB register window
- CNT_W, 32, width of the busy-cycle counter

- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted when valid&ready
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_addr  in  32  byte address
- icb_cmd_wdata  in  32  write data
- icb_cmd_wmask  in  4  byte enables, bit i covers wdata[8i+7:8i]
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response consumed when valid&ready
- icb_rsp_rdata  out  32  read data (0 for writes)
- icb_rsp_err  out  1  decode error
- acc_start  out  1  one-cycle start pulse
- acc_done  in  1  one-cycle completion pulse
- cfg_ifm_addr / cfg_wgt_addr / cfg_ofm_addr  out  32 each  buffer base addresses
- cfg_layer  out  16  layer configuration word
- irq  out  1  level interrupt

## Operation
- Hit: addr[31:12]==BASE_ADDR[31:12] and offset addr[11:0] in map; otherwise err=1, rdata=0, no side effect.
- Map: 0x00 CTRL (bit0 START W1, reads 0; bit1 IRQ_EN RW); 0x04 STATUS (bit0 BUSY RO; bit1 DONE W1C); 0x08 IFM_ADDR RW; 0x0C WGT_ADDR RW; 0x10 OFM_ADDR RW; 0x14 LAYER[15:0] RW, upper bits read 0; 0x18 CYCLE_CNT RO.
- Writes honour wmask per byte; W1 / W1C bits act only if their byte is enabled. Writes to RO registers: ignored, err=0.
- START while BUSY=0: acc_start pulses, BUSY set, CYCLE_CNT cleared. START while BUSY=1: ignored, err=0.
- acc_done while BUSY: BUSY cleared, DONE set. acc_done while idle: ignored.
- CYCLE_CNT increments each cycle BUSY=1, wraps at 2^CNT_W.
- irq = DONE & IRQ_EN, registered.
- Same-cycle DONE W1C and acc_done: set wins (DONE stays 1).

## Timing
- Reset: icb_cmd_ready 0 during reset, 1 after; icb_rsp_valid 0, rdata 0, err 0; all registers 0; acc_start 0; irq 0.
- icb_cmd_ready = queue count < 2 (registered count, no combinational path from icb_rsp_ready).
- Command accepted at edge N → response entry (rdata sampled at N, err) written at N; icb_rsp_valid high from N+1 if queue was empty. Queue is in-order FIFO; push and pop in same cycle legal at count 1.
- rsp_valid/rdata/err held stable until accepted.
- Write side effects visible at N+1: cfg_* outputs update, acc_start high for cycle N+1 only, BUSY=1 from N+1.
- acc_done at edge M → BUSY=0, DONE=1 from M+1; irq from M+2.
- Reset mid-transaction: queue flushed, pending responses dropped, BUSY cleared.

## Structure
- acc_icb_pkg: register offsets, CTRL/STATUS bit positions, BASE window width, rsp_entry_t struct {rdata[31:0], err}.
- Sub-module icb_rsp_fifo: 2-entry FIFO of rsp_entry_t with count, full, empty.

## Test plan
- Reset, read 0x1004_2004 → rsp rdata=0, err=0, one cycle after accept.
- Write 0x08 data 0xDEAD_BEEF wmask 4'b0101 after prior 0 → read returns 0x00AD_00EF; cfg_ifm_addr matches.
- Read 0x1004_2040 and 0x1004_3000 → err=1, rdata=0, no state change.
- Write CTRL=0x3 → acc_start one cycle, STATUS=0x1; 10 cycles later acc_done → STATUS=0x2, CYCLE_CNT≈10, irq=1; write STATUS 0x2 → irq=0.
- Hold icb_rsp_ready=0, issue 3 back-to-back reads → two accepted, icb_cmd_ready=0 for third; release → three responses in order.
- START during BUSY and acc_done in same cycle as DONE W1C → no second pulse, DONE remains 1.
